// File: rtl/uart_sender_pkg.sv
// Shared types for the UART response sender: FSM encoding, packet layout, bytes per packet.
// Define PACKET_CHECKSUM_EN to append a code^data checksum byte to every packet.
package uart_sender_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_e;

`ifdef PACKET_CHECKSUM_EN
    localparam int unsigned PACKET_BYTES = 3;
`else
    localparam int unsigned PACKET_BYTES = 2;
`endif

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] data;
    } packet_t;

    localparam int unsigned PACKET_BITS = $bits(packet_t);

endpackage

// File: rtl/packet_fifo.sv
// Synchronous FIFO with full/empty flags; pointers carry one extra wrap bit.
module packet_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_response_sender.sv
// Buffers {code, data} responses and feeds them byte by byte to the UART transmitter.
// Define PACKET_CHECKSUM_EN to send a third code^data byte per packet.
module uart_response_sender
    import uart_sender_pkg::*;
#(
    parameter int unsigned PACKET_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       packet_valid,
    input  logic [7:0] packet_code,
    input  logic [7:0] packet_data,
    output logic       packet_ready,
    output logic       packet_overflow,
    input  logic       is_transmitting,
    input  logic       transmission_done,
    output logic       has_data,
    output logic [7:0] data_to_send,
    output logic       sender_busy
);

    packet_t          in_pkt, head;
    logic             fifo_full, fifo_empty, pop;
    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic             pend_q, pend_d;
    logic [7:0]       code_q, code_d;
    logic [7:0]       pdat_q, pdat_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       cur_byte;
    logic             done_q, ovf_q;
    logic             done_rise, last_byte;
`ifdef PACKET_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    assign in_pkt = '{code: packet_code, data: packet_data};

    packet_fifo #(
        .DEPTH(PACKET_DEPTH),
        .WIDTH(PACKET_BITS)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (packet_valid),
        .wdata_i (in_pkt),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign packet_ready    = !fifo_full;
    assign packet_overflow = ovf_q;
    assign has_data        = (state_q == S_ISSUE);
    assign data_to_send    = tx_byte_q;
    assign sender_busy     = !fifo_empty || (state_q != S_IDLE);
    assign done_rise       = transmission_done && !done_q;
    assign last_byte       = (idx_q == 2'(PACKET_BYTES - 1));

    always_comb begin
        cur_byte = code_q;
        if (idx_q == 2'd1) cur_byte = pdat_q;
`ifdef PACKET_CHECKSUM_EN
        if (idx_q == 2'd2) cur_byte = csum_q;
`endif
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        code_d    = code_q;
        pdat_d    = pdat_q;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;
`ifdef PACKET_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !is_transmitting) begin
                    code_d    = head.code;
                    pdat_d    = head.data;
`ifdef PACKET_CHECKSUM_EN
                    csum_d    = head.code ^ head.data;
`endif
                    idx_d     = 2'd0;
                    pend_d    = 1'b0;
                    tx_byte_d = head.code;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // pend_q: byte index already advanced, waiting for the transmitter to go idle
                if (pend_q) begin
                    if (!is_transmitting) begin
                        pend_d    = 1'b0;
                        tx_byte_d = cur_byte;
                        state_d   = S_ISSUE;
                    end
                end else if (done_rise) begin
                    if (last_byte) begin
                        pop     = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        pend_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= 2'd0;
            pend_q    <= 1'b0;
            code_q    <= 8'h00;
            pdat_q    <= 8'h00;
            tx_byte_q <= 8'h00;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef PACKET_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            code_q    <= code_d;
            pdat_q    <= pdat_d;
            tx_byte_q <= tx_byte_d;
            done_q    <= transmission_done;
            ovf_q     <= packet_valid && fifo_full;
`ifdef PACKET_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_response_sender.sv
// Directed bench for uart_response_sender with a behavioural UART transmitter model.
module tb_uart_response_sender;
    import uart_sender_pkg::*;

    localparam int CPB = 87;
    localparam int TX_IDLE = 0, TX_START = 1, TX_DATA = 2, TX_STOP = 3, TX_CLEAN = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       packet_valid = 1'b0;
    logic [7:0] packet_code = 8'h00;
    logic [7:0] packet_data = 8'h00;
    logic       packet_ready, packet_overflow;
    logic       is_transmitting;
    logic       transmission_done = 1'b0;
    logic       has_data;
    logic [7:0] data_to_send;
    logic       sender_busy;

    logic       tx_busy = 1'b0;
    logic       tx_hold = 1'b0;
    assign is_transmitting = tx_busy | tx_hold;

    always #5 clock = ~clock;

    uart_response_sender #(.PACKET_DEPTH(4)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .packet_valid      (packet_valid),
        .packet_code       (packet_code),
        .packet_data       (packet_data),
        .packet_ready      (packet_ready),
        .packet_overflow   (packet_overflow),
        .is_transmitting   (is_transmitting),
        .transmission_done (transmission_done),
        .has_data          (has_data),
        .data_to_send      (data_to_send),
        .sender_busy       (sender_busy)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Transmitter model: reads data_to_send live mid-bit, done high for two cleanup cycles.
    int         tx_st = TX_IDLE;
    int         tx_cnt = 0;
    int         tx_bit = 0;
    logic [7:0] tx_sh = 8'h00;
    logic [7:0] rx_q[$];

    always @(posedge clock) begin
        case (tx_st)
            TX_IDLE: begin
                if (has_data) begin
                    tx_st   <= TX_START;
                    tx_cnt  <= 0;
                    tx_busy <= 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt == CPB - 1) begin
                    tx_cnt <= 0;
                    tx_bit <= 0;
                    tx_st  <= TX_DATA;
                end else tx_cnt <= tx_cnt + 1;
            end
            TX_DATA: begin
                if (tx_cnt == CPB / 2) tx_sh[tx_bit] <= data_to_send[tx_bit];
                if (tx_cnt == CPB - 1) begin
                    tx_cnt <= 0;
                    if (tx_bit == 7) tx_st <= TX_STOP;
                    else tx_bit <= tx_bit + 1;
                end else tx_cnt <= tx_cnt + 1;
            end
            TX_STOP: begin
                if (tx_cnt == CPB - 1) begin
                    tx_cnt            <= 0;
                    tx_st             <= TX_CLEAN;
                    transmission_done <= 1'b1;
                    rx_q.push_back(tx_sh);
                end else tx_cnt <= tx_cnt + 1;
            end
            default: begin
                if (tx_cnt == 1) begin
                    tx_st             <= TX_IDLE;
                    transmission_done <= 1'b0;
                    tx_busy           <= 1'b0;
                end else tx_cnt <= tx_cnt + 1;
            end
        endcase
    end

    // Monitor: has_data pulses, overflow pulses, byte stability, done_rise-to-issue gap.
    int         hd_cnt = 0, ovf_cnt = 0, stab_err = 0, min_gap = 1000, last_rise = 0;
    bit         rise_seen = 1'b0, act = 1'b0, mon_pd = 1'b0;
    logic [7:0] held = 8'h00;

    always @(negedge clock) begin
        if (!reset_n) begin
            act = 1'b0;
        end else begin
            if (has_data) begin
                hd_cnt++;
                act  = 1'b1;
                held = data_to_send;
                if (rise_seen && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
            end else if (act && data_to_send !== held) begin
                stab_err++;
            end
            if (transmission_done && !mon_pd) begin
                act       = 1'b0;
                last_rise = cyc;
                rise_seen = 1'b1;
            end
            if (packet_overflow) ovf_cnt++;
        end
        mon_pd = transmission_done;
    end

    int         checks = 0, errors = 0;
    int         rx_base = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic [7:0] c, input logic [7:0] d);
        packet_code  = c;
        packet_data  = d;
        packet_valid = 1'b1;
        @(negedge clock);
        packet_valid = 1'b0;
    endtask

    task automatic add_exp(input logic [7:0] c, input logic [7:0] d);
        exp_q.push_back(c);
        exp_q.push_back(d);
        if (PACKET_BYTES == 3) exp_q.push_back(c ^ d);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((sender_busy || is_transmitting) && n < 20000);
        repeat (3) @(negedge clock);
        check({tag, "_drain_timeout"}, 32'(n >= 20000), 0);
    endtask

    task automatic compare_rx(input string tag);
        int got_n = rx_q.size() - rx_base;
        check({tag, "_rx_len"}, got_n, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_n) check($sformatf("%s_rx_byte%0d", tag, i), rx_q[rx_base + i], exp_q[i]);
        end
        rx_base = rx_q.size();
        exp_q.delete();
    endtask

    initial begin
        int base, t0, n, nh;
        bit found, lpd;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_has_data", has_data, 0);
        check("rst_data_to_send", data_to_send, 8'h00);
        check("rst_overflow", packet_overflow, 0);
        check("rst_busy", sender_busy, 0);
        check("rst_ready", packet_ready, 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Single packet: latency, byte order, pulse count
        base = hd_cnt;
        t0   = cyc;
        offer(8'hA1, 8'h3C);
        add_exp(8'hA1, 8'h3C);
        n = 0;
        while (!has_data && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("single_issue_latency", cyc - t0, 2);
        check("single_data_first", data_to_send, 8'hA1);
        check("single_busy", sender_busy, 1);
        drain("single");
        check("single_pulses", hd_cnt - base, PACKET_BYTES);
        compare_rx("single");

        // Five back-to-back offers into a depth-4 FIFO while the transmitter is busy
        tx_hold = 1'b1;
        base    = ovf_cnt;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("ovf_ready%0d", i), packet_ready, (i < 4) ? 1 : 0);
            packet_code  = 8'h10 + 8'(i);
            packet_data  = 8'h80 + 8'(i);
            packet_valid = 1'b1;
            if (i < 4) add_exp(8'h10 + 8'(i), 8'h80 + 8'(i));
            @(negedge clock);
            if (i == 3) check("ovf_none_before", packet_overflow, 0);
            if (i == 4) check("ovf_pulse", packet_overflow, 1);
        end
        packet_valid = 1'b0;
        @(negedge clock);
        check("ovf_pulse_end", packet_overflow, 0);
        check("ovf_pulse_count", ovf_cnt - base, 1);
        tx_hold = 1'b0;
        drain("ovf");
        compare_rx("ovf");

        // Push into a full FIFO in the cycle the last byte's done edge pops it
        tx_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(8'h20 + 8'(i), 8'h40 + 8'(i));
            add_exp(8'h20 + 8'(i), 8'h40 + 8'(i));
        end
        check("pop_full_ready", packet_ready, 0);
        tx_hold = 1'b0;
        n = 0; nh = 0; found = 1'b0; lpd = transmission_done;
        while (!found && n < 20000) begin
            @(negedge clock);
            n++;
            if (has_data) nh++;
            if (nh == PACKET_BYTES && transmission_done && !lpd) found = 1'b1;
            lpd = transmission_done;
        end
        check("pop_edge_found", 32'(found), 1);
        check("pop_edge_ready", packet_ready, 0);
        packet_code  = 8'hE5;
        packet_data  = 8'h5E;
        packet_valid = 1'b1;
        @(negedge clock);
        check("pop_refused_ovf", packet_overflow, 1);
        check("pop_ready_after", packet_ready, 1);
        @(negedge clock);
        packet_valid = 1'b0;
        check("pop_accept_no_ovf", packet_overflow, 0);
        add_exp(8'hE5, 8'h5E);
        drain("pop");
        compare_rx("pop");

        // Reset mid-data-byte with two packets queued
        tx_hold = 1'b1;
        offer(8'h33, 8'h44);
        offer(8'h55, 8'h66);
        tx_hold = 1'b0;
        n = 0;
        while (!has_data && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (3 * CPB) @(negedge clock);
        check("rstmid_in_data", 32'(tx_st == TX_DATA), 1);
        reset_n = 1'b0;
        #1;
        check("rstmid_has_data", has_data, 0);
        check("rstmid_data", data_to_send, 8'h00);
        check("rstmid_busy", sender_busy, 0);
        check("rstmid_ready", packet_ready, 1);
        check("rstmid_overflow", packet_overflow, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        base = hd_cnt;
        n = 0;
        while (is_transmitting && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("rstmid_tx_finish", 32'(n >= 2000), 0);
        repeat (10) @(negedge clock);
        check("rstmid_no_issue", hd_cnt - base, 0);
        check("rstmid_busy_after", sender_busy, 0);
        check("rstmid_ready_after", packet_ready, 1);
        rx_base = rx_q.size();

        check("data_stable_in_frame", stab_err, 0);
        check("issue_gap_ge2", 32'(min_gap >= 2), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
